// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end: fetch-queue entry
// layout and instruction sizing.
package fetch_unit_pkg;

    localparam int unsigned FQ_XLEN     = 32;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [ILEN-1:0]    data;
        logic               filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are reserved at request, filled by responses
// in order, and popped by decode once the head is filled.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned FQ_DEPTH = 4,
    parameter int unsigned XLEN     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      reserve,
    input  logic [XLEN-1:0]           reserve_pc,
    input  logic                      fill,
    input  logic [ILEN-1:0]           fill_data,
    input  logic                      pop,
    output logic                      head_valid,
    output logic [XLEN-1:0]           head_pc,
    output logic [ILEN-1:0]           head_data,
    output logic [$clog2(FQ_DEPTH):0] count,
    output logic [$clog2(FQ_DEPTH):0] pending
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    fq_entry_t         entries [FQ_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     fill_ptr;

    assign head_valid = (count != '0) && entries[head].filled;
    assign head_pc    = XLEN'(entries[head].pc);
    assign head_data  = entries[head].data;

    // fill_ptr tracks the oldest reserved-but-unfilled entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            count    <= '0;
            pending  <= '0;
        end else if (flush) begin
            head     <= tail;
            fill_ptr <= tail;
            count    <= '0;
            pending  <= '0;
        end else begin
            if (reserve) begin
                entries[tail] <= '{pc: FQ_XLEN'(reserve_pc), data: '0, filled: 1'b0};
                tail          <= tail + PW'(1);
            end
            if (fill) begin
                entries[fill_ptr].data   <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count   <= count + CW'(reserve) - CW'(pop);
            pending <= pending + CW'(reserve) - CW'(fill);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: pipelined memory requests, in-order fetch
// queue towards decode, and redirect flush with squashing of stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   count;
    logic [CW-1:0]   pending;
    logic            head_valid;
    logic            has_credit;
    logic            fire;
    logic            fill;
    logic            drop;
    logic            pop;

    // Every reserved entry and every response still to be discarded holds a credit
    assign has_credit = (SW'(count) + SW'(discard)) < SW'(FQ_DEPTH);
    assign req_valid  = reset && !redirect_valid && has_credit;
    assign req_addr   = fetch_pc;
    assign fire       = req_valid && req_ready;

    assign drop = rsp_valid && (discard != '0);
    assign fill = rsp_valid && !redirect_valid && (discard == '0) && (pending != '0);

    assign inst_valid = reset && head_valid;
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign busy       = reset && ((count != '0) || (discard != '0));

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH),
        .XLEN     (XLEN)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .reserve    (fire),
        .reserve_pc (fetch_pc),
        .fill       (fill),
        .fill_data  (rsp_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_pc    (inst_pc),
        .head_data  (inst_data),
        .count      (count),
        .pending    (pending)
    );

    // Redirect turns all unfilled reservations into responses to be dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= XLEN'(RESET_PC);
            discard  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
            discard  <= discard + pending - CW'(rsp_valid);
        end else begin
            if (fire) begin
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            end
            if (drop) begin
                discard <= discard - CW'(1);
            end
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        rsp_valid |-> ((discard != '0) || (pending != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order latency memory model plus a
// credit/stream reference model, directed scenarios and a randomized run.
module tb_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
        int unsigned ep;
    } mreq_t;

    mreq_t       mq[$];
    int unsigned cyc;
    int unsigned lat;
    int unsigned epoch;
    int unsigned fires;
    int unsigned pops;
    int unsigned fills;
    logic [31:0] exp_req;
    logic [31:0] exp_pop;
    int          checks;
    int          passed;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic int unsigned stale_cnt();
        int unsigned n = 0;
        foreach (mq[i]) if (mq[i].ep != epoch) n++;
        return n;
    endfunction

    // One clock: capture handshakes, advance memory and reference model
    task automatic tick();
        logic fire, pop, redir, rst, rsp;
        logic [31:0] faddr, tgt;
        #1;
        fire  = req_valid && req_ready;
        faddr = req_addr;
        pop   = inst_valid && inst_ready;
        redir = redirect_valid;
        tgt   = redirect_pc;
        rst   = reset;
        rsp   = rsp_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            mq.delete();
            epoch++;
            fires = 0; pops = 0; fills = 0;
            exp_req = RESET_PC;
            exp_pop = RESET_PC;
        end else begin
            if (rsp && mq.size() > 0) begin
                if (!redir && mq[0].ep == epoch) fills++;
                mq.delete(0);
            end
            if (redir) begin
                epoch++;
                fires = 0; pops = 0; fills = 0;
                exp_req = tgt & ~32'h3;
                exp_pop = exp_req;
            end else begin
                if (fire) begin
                    mq.push_back('{due: cyc + lat - 1, addr: faddr, ep: epoch});
                    fires++;
                    exp_req += 32'd4;
                end
                if (pop) begin
                    pops++;
                    exp_pop += 32'd4;
                end
            end
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mq[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; redirect_valid = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", req_valid); else passed++;
            checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", inst_valid); else passed++;
            checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
            tick();
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++; if (req_valid !== 1'b1 || req_addr !== 32'(4 * c))
                $display("FAIL stream_req c=%0d: got v=%b a=%h want v=1 a=%h", c, req_valid, req_addr, 32'(4 * c));
            else passed++;
            checks++; if (inst_valid !== (c >= 2))
                $display("FAIL stream_inst_valid c=%0d: got %b want %b", c, inst_valid, c >= 2);
            else passed++;
            if (c >= 2) begin
                checks++; if (inst_pc !== 32'(4 * (c - 2)) || inst_data !== mem_word(32'(4 * (c - 2))))
                    $display("FAIL stream_inst c=%0d: got pc=%h d=%h want pc=%h d=%h", c, inst_pc, inst_data,
                             32'(4 * (c - 2)), mem_word(32'(4 * (c - 2))));
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (req_valid !== (c < 4)) $display("FAIL full_req_valid c=%0d: got %b want %b", c, req_valid, c < 4);
            else passed++;
            if (c < 4) begin
                checks++; if (req_addr !== 32'(4 * c)) $display("FAIL full_req_addr c=%0d: got %h want %h", c, req_addr, 32'(4 * c));
                else passed++;
            end
            tick();
        end
        inst_ready = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) $display("FAIL full_head: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc);
        else passed++;
        checks++; if (req_valid !== 1'b0) $display("FAIL full_pop_cycle_req: got %b want 0", req_valid); else passed++;
        tick();
        inst_ready = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h10) $display("FAIL full_refill: got v=%b a=%h want v=1 a=10", req_valid, req_addr);
        else passed++;
        tick();
        #1;
        checks++; if (req_valid !== 1'b0) $display("FAIL full_again: got %b want 0", req_valid); else passed++;
        checks++; if (inst_pc !== 32'h4) $display("FAIL full_next_head: got %h want 4", inst_pc); else passed++;
    endtask

    task automatic test_redirect_discard();
        int rsps = 0;
        bit found = 1'b0;
        do_reset();
        lat = 4; req_ready = 1'b1; inst_ready = 1'b1;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (req_valid !== 1'b0) $display("FAIL redir_req_in_redirect: got %b want 0", req_valid); else passed++;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0 || busy !== 1'b1) $display("FAIL redir_flushed: got iv=%b busy=%b want iv=0 busy=1", inst_valid, busy);
        else passed++;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h100) $display("FAIL redir_first_req: got v=%b a=%h want v=1 a=100", req_valid, req_addr);
        else passed++;
        for (int c = 0; c < 20 && !found; c++) begin
            #1;
            if (inst_valid) found = 1'b1;
            else begin
                if (rsp_valid) rsps++;
                tick();
            end
        end
        checks++; if (!found) $display("FAIL redir_timeout: got no inst_valid want inst_valid within 20 cycles");
        else if (inst_pc !== 32'h100 || inst_data !== mem_word(32'h100))
            $display("FAIL redir_first_inst: got pc=%h d=%h want pc=100 d=%h", inst_pc, inst_data, mem_word(32'h100));
        else passed++;
        checks++; if (rsps - 1 !== 3) $display("FAIL redir_dropped: got %0d want 3", rsps - 1); else passed++;
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
        tick();
        req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL coinc_redirect_cycle: got rv=%b iv=%b want 0 0", req_valid, inst_valid);
        else passed++;
        tick();
        redirect_valid = 1'b0; req_ready = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || inst_valid !== 1'b0) $display("FAIL coinc_after: got busy=%b iv=%b want 0 0", busy, inst_valid);
        else passed++;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h40) $display("FAIL coinc_req: got v=%b a=%h want v=1 a=40", req_valid, req_addr);
        else passed++;
        tick();
        tick();
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) $display("FAIL coinc_inst: got v=%b pc=%h want v=1 pc=40", inst_valid, inst_pc);
        else passed++;
    endtask

    task automatic test_unaligned_redirect();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0; req_ready = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== 32'h200) $display("FAIL unaligned: got v=%b a=%h want v=1 a=200", req_valid, req_addr);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        lat = 2; req_ready = 1'b1; inst_ready = 1'b0;
        tick(); tick(); tick();
        req_ready = 1'b0;
        tick();
        #1;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) $display("FAIL rmid_pre: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc);
        else passed++;
        reset = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rmid_assert: got rv=%b iv=%b busy=%b want 0 0 0", req_valid, inst_valid, busy);
        else passed++;
        tick();
        #1;
        checks++; if (inst_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rmid_held: got iv=%b busy=%b want 0 0", inst_valid, busy);
        else passed++;
        reset = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b1 || req_addr !== RESET_PC || inst_valid !== 1'b0)
            $display("FAIL rmid_release: got rv=%b a=%h iv=%b want 1 %h 0", req_valid, req_addr, inst_valid, RESET_PC);
        else passed++;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (inst_valid) found = 1'b1;
            else tick();
        end
        checks++; if (!found || inst_pc !== RESET_PC) $display("FAIL rmid_first_inst: got found=%b pc=%h want 1 %h", found, inst_pc, RESET_PC);
        else passed++;
    endtask

    task automatic test_random();
        int unsigned live, st;
        bit e_rv, e_iv, e_busy;
        do_reset();
        lat = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) lat = $urandom_range(1, 4);
            req_ready      = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom;
            reset          = ($urandom_range(0, 199) != 0);
            #1;
            live   = fires - pops;
            st     = stale_cnt();
            e_rv   = reset && !redirect_valid && (live + st < DEPTH);
            e_iv   = reset && (fills > pops);
            e_busy = reset && (live + st != 0);
            checks++; if (req_valid !== e_rv) $display("FAIL rnd_req_valid cyc=%0d: got %b want %b", cyc, req_valid, e_rv); else passed++;
            if (e_rv) begin
                checks++; if (req_addr !== exp_req) $display("FAIL rnd_req_addr cyc=%0d: got %h want %h", cyc, req_addr, exp_req); else passed++;
            end
            checks++; if (inst_valid !== e_iv) $display("FAIL rnd_inst_valid cyc=%0d: got %b want %b", cyc, inst_valid, e_iv); else passed++;
            if (e_iv) begin
                checks++; if (inst_pc !== exp_pop || inst_data !== mem_word(exp_pop))
                    $display("FAIL rnd_inst cyc=%0d: got pc=%h d=%h want pc=%h d=%h", cyc, inst_pc, inst_data, exp_pop, mem_word(exp_pop));
                else passed++;
            end
            checks++; if (busy !== e_busy) $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, busy, e_busy); else passed++;
            tick();
        end
        reset = 1'b1; redirect_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; passed = 0; cyc = 0; lat = 1; epoch = 0;
        fires = 0; pops = 0; fills = 0;
        exp_req = RESET_PC; exp_pop = RESET_PC;
        reset = 1'b0; req_ready = 1'b0; inst_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_discard();
        test_redirect_coincident();
        test_unaligned_redirect();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
